// File: rtl/alu_pkg.sv
// Shared opcode encodings and command layout for the ALU issue path.
// No timing of its own; pure type/constant definitions.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
    } alu_cmd_t;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU: add/sub/and/or, results wrap modulo 16.
// Zero latency; no flow control.
module alu
    import alu_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [1:0] i_op,
    output logic [3:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO with head-of-queue data visible combinationally.
// Latency: write visible at head the cycle after push; push ignored when full, pop ignored when empty.
module alu_cmd_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head_dat
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == OCC_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_head_dat = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Queues ALU commands, drives the external ALU from the queue head, registers result/op/zero.
// Latency: one cycle from command accept to res_valid; cmd_ready drops when the queue is full, res_ready stalls the head.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [1:0]       cmd_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_op,
    input  logic [3:0]       alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic [1:0]       res_op,
    output logic             res_zero,
    output logic [CNT_W-1:0] res_count
);

    alu_cmd_t         w_push_dat;
    alu_cmd_t         w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_hand;

    logic             r_res_valid;
    logic [3:0]       r_res_data;
    logic [1:0]       r_res_op;
    logic             r_res_zero;
    logic [CNT_W-1:0] r_res_count;

    always_comb begin
        w_push_dat    = '0;
        w_push_dat.a  = cmd_a;
        w_push_dat.b  = cmd_b;
        w_push_dat.op = cmd_op;
    end

    alu_cmd_fifo #(
        .WIDTH ($bits(alu_cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_push     (cmd_valid),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head_dat (w_head)
    );

    assign cmd_ready = !w_full;
    assign w_pop     = !w_empty && (!r_res_valid || res_ready);
    assign w_hand    = r_res_valid && res_ready;

    // Empty queue drives zeros so the ALU never sees stale storage.
    assign alu_a  = w_empty ? 4'd0 : w_head.a;
    assign alu_b  = w_empty ? 4'd0 : w_head.b;
    assign alu_op = w_empty ? 2'd0 : w_head.op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
            r_res_zero  <= 1'b1;
            r_res_count <= '0;
        end else begin
            if (w_pop) begin
                r_res_valid <= 1'b1;
                r_res_data  <= alu_out;
                r_res_op    <= w_head.op;
                r_res_zero  <= (alu_out == 4'd0);
            end else if (w_hand) begin
                r_res_valid <= 1'b0;
            end
            if (w_hand && (r_res_count != {CNT_W{1'b1}})) begin
                r_res_count <= r_res_count + CNT_W'(1);
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;
    assign res_zero  = r_res_zero;
    assign res_count = r_res_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with the real alu in the loop and a result scoreboard.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic       zero;
        logic [1:0] op;
        logic [3:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic [1:0]       cmd_op;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [1:0]       alu_op;
    logic [3:0]       alu_out;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_data;
    logic [1:0]       res_op;
    logic             res_zero;
    logic [CNT_W-1:0] res_count;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb[$];

    alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_zero  (res_zero),
        .res_count (res_count)
    );

    alu u_alu (
        .i_a  (alu_a),
        .i_b  (alu_b),
        .i_op (alu_op),
        .o_y  (alu_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        exp_t e;
        logic [3:0] d;
        case (op)
            2'd0:    d = a + b;
            2'd1:    d = a - b;
            2'd2:    d = a & b;
            default: d = a | b;
        endcase
        e.data = d;
        e.op   = op;
        e.zero = (d == 4'd0);
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
    endtask

    // Scoreboard: inputs are stable from just after one rising edge to the next,
    // so what is seen here is exactly what the coming edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("stale_result", {31'd0, res_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_data", {28'd0, res_data}, {28'd0, e.data});
                    chk("res_op",   {30'd0, res_op},   {30'd0, e.op});
                    chk("res_zero", {31'd0, res_zero}, {31'd0, e.zero});
                end
            end
            if (cmd_valid && cmd_ready) sb.push_back(model(cmd_a, cmd_b, cmd_op));
        end
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_zero",  res_zero, 1);
        chk("rst_res_count", res_count, 0);
        chk("rst_res_data",  res_data, 0);
        chk("rst_res_op",    res_op, 0);
        chk("rst_alu_a",     alu_a, 0);
        chk("rst_alu_b",     alu_b, 0);
        chk("rst_alu_op",    alu_op, 0);
        cyc();

        // One op per cycle, a=5 b=3, all four opcodes
        for (int i = 0; i < 4; i++) begin
            drive(4'd5, 4'd3, i[1:0]);
            @(negedge clk);
            chk("single_cmd_ready", cmd_ready, 1);
            if (i == 1) begin
                chk("latency_not_yet", res_valid, 0);
                chk("head_alu_a",  alu_a, 5);
                chk("head_alu_b",  alu_b, 3);
                chk("head_alu_op", alu_op, 0);
            end
            if (i == 2) begin
                chk("latency_valid", res_valid, 1);
                chk("latency_data",  res_data, 8);
                chk("head_alu_op2",  alu_op, 1);
            end
            cyc();
        end
        cmd_valid = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        chk("single_count", res_count, 4);
        chk("single_idle",  res_valid, 0);
        chk("single_hold_data", res_data, 7);
        chk("single_hold_op",   res_op, 3);
        chk("single_hold_zero", res_zero, 0);
        cyc();

        // Modulo-16 wrap and zero flag
        drive(4'd12, 4'd7, OP_ADD); cyc();
        drive(4'd12, 4'd7, OP_SUB); cyc();
        drive(4'd3, 4'd3, OP_SUB);  cyc();
        cmd_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("zero_valid", res_valid, 1);
        chk("zero_data",  res_data, 0);
        chk("zero_flag",  res_zero, 1);
        cyc();

        // Backpressure until full: 5 accepted, 6th blocked
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(4'(i + 1), 4'd2, i[1:0]);
            @(negedge clk);
            chk("fill_cmd_ready", cmd_ready, (i < 5) ? 32'd1 : 32'd0);
            cyc();
        end
        @(negedge clk);
        chk("full_hold_ready", cmd_ready, 0);
        chk("full_res_valid",  res_valid, 1);
        cyc();
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("drain_res_valid", res_valid, (k < 5) ? 32'd1 : 32'd0);
            if (k == 0) chk("drain_ready_before_pop", cmd_ready, 0);
            if (k == 1) chk("drain_ready_after_pop", cmd_ready, 1);
            cyc();
        end

        // Simultaneous push/pop with two queued
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'(i), 4'd9, OP_OR);
            cyc();
        end
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(4'(i + 7), 4'(i), i[1:0]);
            @(negedge clk);
            chk("stream_cmd_ready", cmd_ready, 1);
            cyc();
        end
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stream_occupancy", res_valid, (k < 3) ? 32'd1 : 32'd0);
            cyc();
        end

        // Reset with a held result and three queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(4'(i + 4), 4'd1, OP_ADD);
            cyc();
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", res_valid, 1);
        chk("pre_rst_ready", cmd_ready, 1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_count", res_count, 0);
        chk("mid_rst_zero",  res_zero, 1);
        chk("mid_rst_data",  res_data, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        cyc();
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_no_result", res_valid, 0);
            cyc();
        end
        drive(4'd6, 4'd10, OP_AND);
        cyc();
        cmd_valid = 1'b0;
        repeat (3) cyc();

        // Counter saturation
        for (int i = 0; i < 260; i++) begin
            drive(i[3:0], i[7:4], i[1:0]);
            cyc();
        end
        cmd_valid = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("count_saturate", res_count, 255);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
